// File: rtl/input_pkg.sv
// Shared types and constants for the player input conditioning path.
package input_pkg;

    typedef enum logic [1:0] {
        REL,
        PEND_P,
        HELD,
        PEND_R
    } deb_state_t;

    localparam int unsigned P1_LEFT   = 0;
    localparam int unsigned P1_RIGHT  = 1;
    localparam int unsigned P1_ATTACK = 2;
    localparam int unsigned P2_LEFT   = 3;
    localparam int unsigned P2_RIGHT  = 4;
    localparam int unsigned P2_ATTACK = 5;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, debounce FSM with stability counter,
// registered level and press pulse.
module debounce_channel
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_raw,
    output logic level,
    output logic press_pulse,
    output logic level_next,
    output logic press_pulse_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_pulse_q, press_pulse_d;
    logic                   s;

    assign s = ~sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_n_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            REL: begin
                if (s) begin
                    state_d = PEND_P;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_P: begin
                if (!s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = PEND_R;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_R: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
        // Level follows the registered state, adding the final cycle of latency.
        level_d       = (state_q == HELD) || (state_q == PEND_R);
        press_pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q        <= '1;
            state_q       <= REL;
            cnt_q         <= '0;
            level_q       <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign level            = level_q;
    assign press_pulse      = press_pulse_q;
    assign level_next       = level_d;
    assign press_pulse_next = press_pulse_d;

endmodule

// File: rtl/player_input_conditioner.sv
// Debounces all player buttons and re-latches them once per game frame with
// sticky press bits so presses between frames are never lost.
module player_input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned NCH             = 6,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] btn_n_raw,
    input  logic           frame_tick,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] press_pulse,
    output logic [NCH-1:0] frame_level,
    output logic [NCH-1:0] frame_press,
    output logic           any_press
);

    logic [NCH-1:0] level_next, press_pulse_next;
    logic [NCH-1:0] acc_q, acc_d;
    logic [NCH-1:0] frame_level_q, frame_level_d;
    logic [NCH-1:0] frame_press_q, frame_press_d;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_deb (
            .clk             (clk),
            .rst_n           (rst_n),
            .btn_n_raw       (btn_n_raw[i]),
            .level           (level[i]),
            .press_pulse     (press_pulse[i]),
            .level_next      (level_next[i]),
            .press_pulse_next(press_pulse_next[i])
        );
    end

    always_comb begin
        acc_d         = acc_q | press_pulse_next;
        frame_level_d = frame_level_q;
        frame_press_d = frame_press_q;
        // A pulse landing on the tick edge is reported now, not carried over.
        if (frame_tick) begin
            frame_press_d = acc_q | press_pulse_next;
            frame_level_d = level_next;
            acc_d         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q         <= '0;
            frame_level_q <= '0;
            frame_press_q <= '0;
        end else begin
            acc_q         <= acc_d;
            frame_level_q <= frame_level_d;
            frame_press_q <= frame_press_d;
        end
    end

    assign frame_level = frame_level_q;
    assign frame_press = frame_press_q;
    assign any_press   = |press_pulse;

endmodule

// File: tb/tb_player_input_conditioner.sv
// Randomized and directed bench for player_input_conditioner against a
// run-length debounce model with frame accumulation.
module tb_player_input_conditioner;

    localparam int unsigned NCH = 6;
    localparam int unsigned DEB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] btn_n_raw;
    logic           frame_tick;
    logic [NCH-1:0] level, press_pulse, frame_level, frame_press;
    logic           any_press;

    always #5 clk = ~clk;

    player_input_conditioner #(
        .NCH            (NCH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n_raw  (btn_n_raw),
        .frame_tick (frame_tick),
        .level      (level),
        .press_pulse(press_pulse),
        .frame_level(frame_level),
        .frame_press(frame_press),
        .any_press  (any_press)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raw delayed two samples, accepted value changes after DEB
    // consecutive disagreeing samples, outputs appear one cycle later.
    logic [NCH-1:0] m_sync0, m_sync1, m_accepted;
    logic [NCH-1:0] m_level, m_pulse, m_acc, m_fl, m_fp;
    logic [NCH-1:0] lvl_new, pulse_new;
    int             m_run [NCH];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sync0 = '1; m_sync1 = '1; m_accepted = '0;
            m_level = '0; m_pulse = '0; m_acc = '0; m_fl = '0; m_fp = '0;
            for (int i = 0; i < NCH; i++) m_run[i] = 0;
        end else begin
            lvl_new   = m_accepted;
            pulse_new = lvl_new & ~m_level;
            for (int i = 0; i < NCH; i++) begin
                if (~m_sync1[i] != m_accepted[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_accepted[i] = ~m_sync1[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (frame_tick) begin
                m_fp  = m_acc | pulse_new;
                m_fl  = lvl_new;
                m_acc = '0;
            end else begin
                m_acc = m_acc | pulse_new;
            end
            m_sync1 = m_sync0;
            m_sync0 = btn_n_raw;
            m_level = lvl_new;
            m_pulse = pulse_new;
        end
    end

    task automatic check_all();
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("press_pulse", 32'(press_pulse), 32'(m_pulse));
        check_eq("frame_level", 32'(frame_level), 32'(m_fl));
        check_eq("frame_press", 32'(frame_press), 32'(m_fp));
        check_eq("any_press", 32'(any_press), 32'(|m_pulse));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    int hits;

    initial begin
        rst_n      = 1'b0;
        btn_n_raw  = '1;
        frame_tick = 1'b0;
        @(negedge clk);
        steps(2);
        check_eq("rst_level", 32'(level), 32'(0));
        check_eq("rst_frame_press", 32'(frame_press), 32'(0));
        rst_n = 1'b1;
        steps(4);

        // Clean press on channel 0: level and pulse at edge 6
        btn_n_raw[0] = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            step();
            check_eq("clean_level0", 32'(level[0]), 32'(k >= 6));
            check_eq("clean_pulse0", 32'(press_pulse[0]), 32'(k == 6));
            check_eq("clean_others", 32'(level[5:1]), 32'(0));
        end
        btn_n_raw[0] = 1'b1;
        steps(10);

        // Bounce shorter than the debounce window on channel 2
        btn_n_raw[2] = 1'b0;
        steps(3);
        btn_n_raw[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("bounce_level2", 32'(level[2]), 32'(0));
            check_eq("bounce_pulse2", 32'(press_pulse[2]), 32'(0));
        end

        // Sticky frame: press and release of ch4 inside one 40-cycle frame
        tick();
        btn_n_raw[4] = 1'b0;
        steps(8);
        btn_n_raw[4] = 1'b1;
        steps(31);
        tick();
        check_eq("sticky_press", 32'(frame_press), 32'(6'b010000));
        check_eq("sticky_level4", 32'(frame_level[4]), 32'(0));
        steps(10);
        tick();
        check_eq("sticky_clear", 32'(frame_press), 32'(0));

        // Press pulse on the same edge as the frame tick
        btn_n_raw[1] = 1'b0;
        steps(6);
        tick();
        check_eq("same_pulse1", 32'(press_pulse[1]), 32'(1));
        check_eq("same_fpress1", 32'(frame_press[1]), 32'(1));
        check_eq("same_flevel1", 32'(frame_level[1]), 32'(1));
        steps(5);
        tick();
        check_eq("same_next_fpress1", 32'(frame_press[1]), 32'(0));
        check_eq("same_next_flevel1", 32'(frame_level[1]), 32'(1));
        btn_n_raw[1] = 1'b1;
        steps(10);

        // Simultaneous presses on ch0 and ch5
        btn_n_raw[0] = 1'b0;
        btn_n_raw[5] = 1'b0;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (any_press) hits++;
            if (k == 6) check_eq("simul_pulses", 32'(press_pulse), 32'(6'b100001));
        end
        check_eq("simul_any_once", 32'(hits), 32'(1));
        btn_n_raw[0] = 1'b1;
        btn_n_raw[5] = 1'b1;
        steps(10);

        // Reset while ch3 is held; it re-qualifies after release
        btn_n_raw[3] = 1'b0;
        steps(10);
        check_eq("hold_level3", 32'(level[3]), 32'(1));
        rst_n = 1'b0;
        step();
        check_eq("rst_mid_level", 32'(level), 32'(0));
        check_eq("rst_mid_pulse", 32'(press_pulse), 32'(0));
        check_eq("rst_mid_any", 32'(any_press), 32'(0));
        rst_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            check_eq("rst_requal_level3", 32'(level[3]), 32'(k >= 6));
            check_eq("rst_requal_pulse3", 32'(press_pulse[3]), 32'(k == 6));
        end
        btn_n_raw = '1;
        steps(10);

        // Randomized activity checked against the model every cycle
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(5) == 0) btn_n_raw[$urandom_range(NCH - 1)] ^= 1'b1;
            frame_tick = ($urandom_range(11) == 0);
            rst_n      = ($urandom_range(299) != 0);
            step();
        end
        frame_tick = 1'b0;
        rst_n      = 1'b1;
        steps(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
